// File: rtl/irs_dac_loader.sv
// Serial loader for the IRS DAC/config chain: LOAD/BUSY/DONE handshake, MSB-first SCLK/SIN shift, PCLK commit.
// Optional IRS_DAC_READBACK_EN captures SHOUT into READBACK and flags MISMATCH against the previous pattern.
module irs_dac_loader #(
    parameter int NBITS        = 145,
    parameter int CLKDIV       = 256,
    parameter int REGCLR_TICKS = 2,
    parameter int PCLK_TICKS   = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [NBITS-1:0] DATA,
    input  logic             CLEAR,
    input  logic             LOAD,
    output logic             BUSY,
    output logic             DONE,
    output logic             SCLK,
    output logic             SIN,
    input  logic             SHOUT,
    output logic             PCLK,
    output logic             REGCLR,
    output logic [NBITS-1:0] READBACK,
    output logic             MISMATCH
);
    localparam int DIV_W = $clog2(CLKDIV);
    localparam int BIT_W = $clog2(NBITS);
    localparam int TMAX  = (REGCLR_TICKS > PCLK_TICKS) ? REGCLR_TICKS : PCLK_TICKS;
    localparam int TCK_W = (TMAX > 1) ? $clog2(TMAX) : 1;

    typedef enum logic [2:0] {IDLE, CLR, SLO, SHI, LATCH} state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [BIT_W-1:0] bit_q, bit_d;
    logic [TCK_W-1:0] tck_q, tck_d;
    logic [NBITS-1:0] sr_q, sr_d;
    logic             tick;
    logic busy_q, done_q, sclk_q, sin_q, pclk_q, regclr_q;
    logic busy_d, done_d, sclk_d, sin_d, pclk_d, regclr_d;

    assign tick = (div_q == DIV_W'(CLKDIV - 1));

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            div_q    <= '0;
            bit_q    <= '0;
            tck_q    <= '0;
            sr_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            sclk_q   <= 1'b0;
            sin_q    <= 1'b0;
            pclk_q   <= 1'b0;
            regclr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
            tck_q    <= tck_d;
            sr_q     <= sr_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            sclk_q   <= sclk_d;
            sin_q    <= sin_d;
            pclk_q   <= pclk_d;
            regclr_q <= regclr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        tck_d   = tck_q;
        sr_d    = sr_q;
        div_d   = (state_q == IDLE || tick) ? '0 : div_q + 1'b1;
        case (state_q)
            IDLE: begin
                if (LOAD) begin
                    sr_d    = DATA;
                    bit_d   = '0;
                    tck_d   = '0;
                    state_d = CLEAR ? CLR : SLO;
                end
            end
            CLR: begin
                if (tick) begin
                    if (tck_q == TCK_W'(REGCLR_TICKS - 1)) begin
                        tck_d   = '0;
                        state_d = SLO;
                    end else begin
                        tck_d = tck_q + 1'b1;
                    end
                end
            end
            SLO: begin
                if (tick) state_d = SHI;
            end
            SHI: begin
                if (tick) begin
                    sr_d = {sr_q[NBITS-2:0], 1'b0};
                    if (bit_q == BIT_W'(NBITS - 1)) begin
                        state_d = LATCH;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        state_d = SLO;
                    end
                end
            end
            LATCH: begin
                if (tick) begin
                    if (tck_q == TCK_W'(PCLK_TICKS - 1)) begin
                        tck_d   = '0;
                        state_d = IDLE;
                    end else begin
                        tck_d = tck_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Pins are decoded from the next state so each register flips together with the FSM.
    // BUSY uses the current state as well, so it rises one cycle after the accepting edge.
    always_comb begin
        busy_d   = (state_q != IDLE) && (state_d != IDLE);
        done_d   = (state_q == LATCH) && (state_d == IDLE);
        sclk_d   = (state_d == SHI);
        sin_d    = ((state_d == SLO) || (state_d == SHI)) ? sr_d[NBITS-1] : 1'b0;
        pclk_d   = (state_d == LATCH);
        regclr_d = (state_d == CLR);
    end

    assign BUSY   = busy_q;
    assign DONE   = done_q;
    assign SCLK   = sclk_q;
    assign SIN    = sin_q;
    assign PCLK   = pclk_q;
    assign REGCLR = regclr_q;

`ifdef IRS_DAC_READBACK_EN
    logic [NBITS-1:0] rb_q, last_q, data_q;
    logic             ref_valid_q, mismatch_q;

    // The reference is the pattern committed by the previous load, not the one just shifted.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rb_q        <= '0;
            last_q      <= '0;
            data_q      <= '0;
            ref_valid_q <= 1'b0;
            mismatch_q  <= 1'b0;
        end else begin
            if (state_q == IDLE && LOAD) begin
                data_q     <= DATA;
                mismatch_q <= 1'b0;
            end
            if (state_q == SHI && tick) rb_q <= {rb_q[NBITS-2:0], SHOUT};
            if (done_d) begin
                last_q      <= data_q;
                ref_valid_q <= 1'b1;
                mismatch_q  <= ref_valid_q && (rb_q != last_q);
            end
        end
    end

    assign READBACK = rb_q;
    assign MISMATCH = mismatch_q;
`else
    logic unused_shout;
    assign unused_shout = SHOUT;
    assign READBACK     = '0;
    assign MISMATCH     = 1'b0;
`endif

endmodule
